// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window generator and the Sobel stage.
package sobel_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int WIN_N     = 9;

  // Row-major position of each pixel in the 3x3 window.
  typedef enum logic [3:0] {
    WIN_TL = 4'd0,
    WIN_TC = 4'd1,
    WIN_TR = 4'd2,
    WIN_ML = 4'd3,
    WIN_MC = 4'd4,
    WIN_MR = 4'd5,
    WIN_BL = 4'd6,
    WIN_BC = 4'd7,
    WIN_BR = 4'd8
  } win_idx_e;

endpackage

// File: rtl/sobel_line_buf.sv
// Two-line pixel buffer sharing one column address: each word holds
// {line r-2, line r-1}. Combinational read, the write shifts the column.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIX_W-1:0]         pix,
  output logic [PIX_W-1:0]         lb0_q,
  output logic [PIX_W-1:0]         lb1_q
);

  logic [2*PIX_W-1:0] mem [DEPTH];

  assign lb0_q = mem[addr][PIX_W-1:0];
  assign lb1_q = mem[addr][2*PIX_W-1:PIX_W];

  // Older line moves up, new pixel enters the recent line; contents never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= {mem[addr][PIX_W-1:0], pix};
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 window converter feeding the Sobel stage.
// Single output slot: a new pixel is taken only when the slot is free or being drained.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk_i_s,
  input  logic             rst_i_s,
  input  logic [PIX_W-1:0] pix_i,
  input  logic             pix_valid_i,
  input  logic             sof_i,
  output logic             pix_ready_o,
  output logic [PIX_W-1:0] data_o_0,
  output logic [PIX_W-1:0] data_o_1,
  output logic [PIX_W-1:0] data_o_2,
  output logic [PIX_W-1:0] data_o_3,
  output logic [PIX_W-1:0] data_o_4,
  output logic [PIX_W-1:0] data_o_5,
  output logic [PIX_W-1:0] data_o_6,
  output logic [PIX_W-1:0] data_o_7,
  output logic [PIX_W-1:0] data_o_8,
  output logic             win_valid_o,
  input  logic             win_ready_i,
  output logic             frame_done_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]    col, c_eff;
  logic [RW-1:0]    row, r_eff;
  logic             acc, last_col, last_row, interior;
  logic [PIX_W-1:0] lb0_q, lb1_q;
  logic [PIX_W-1:0] win_p1 [WIN_N];
  logic             vld_p1, done_p1;

  assign pix_ready_o = !vld_p1 | win_ready_i;
  assign acc         = pix_valid_i & pix_ready_o;

  // A start-of-frame pixel is always placed at (0,0), whatever the counters say.
  assign c_eff    = sof_i ? '0 : col;
  assign r_eff    = sof_i ? '0 : row;
  assign last_col = (c_eff == CW'(IMG_W - 1));
  assign last_row = (r_eff == RW'(IMG_H - 1));
  assign interior = (r_eff >= RW'(2)) && (c_eff >= CW'(2));

  sobel_line_buf #(
    .DEPTH (IMG_W),
    .PIX_W (PIX_W)
  ) u_line_buf (
    .clk   (clk_i_s),
    .we    (acc),
    .addr  (c_eff),
    .pix   (pix_i),
    .lb0_q (lb0_q),
    .lb1_q (lb1_q)
  );

  // Raster position of the next pixel; wraps per line and per frame.
  always_ff @(posedge clk_i_s) begin
    if (rst_i_s) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : r_eff + RW'(1);
      end else begin
        col <= c_eff + CW'(1);
        row <= r_eff;
      end
    end
  end

  // ---- stage p1: window shift, right column = {line r-2, line r-1, new pixel}
  always_ff @(posedge clk_i_s) begin
    if (rst_i_s) begin
      for (int i = 0; i < WIN_N; i++) win_p1[i] <= '0;
    end else if (acc) begin
      win_p1[WIN_TL] <= win_p1[WIN_TC];
      win_p1[WIN_TC] <= win_p1[WIN_TR];
      win_p1[WIN_TR] <= lb1_q;
      win_p1[WIN_ML] <= win_p1[WIN_MC];
      win_p1[WIN_MC] <= win_p1[WIN_MR];
      win_p1[WIN_MR] <= lb0_q;
      win_p1[WIN_BL] <= win_p1[WIN_BC];
      win_p1[WIN_BC] <= win_p1[WIN_BR];
      win_p1[WIN_BR] <= pix_i;
    end
  end

  // Output slot occupancy and the end-of-frame pulse.
  always_ff @(posedge clk_i_s) begin
    if (rst_i_s) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      done_p1 <= acc & last_col & last_row;
      if (acc) vld_p1 <= interior;
      else     vld_p1 <= vld_p1 & !win_ready_i;
    end
  end

  assign win_valid_o  = vld_p1;
  assign frame_done_o = done_p1;
  assign data_o_0     = win_p1[WIN_TL];
  assign data_o_1     = win_p1[WIN_TC];
  assign data_o_2     = win_p1[WIN_TR];
  assign data_o_3     = win_p1[WIN_ML];
  assign data_o_4     = win_p1[WIN_MC];
  assign data_o_5     = win_p1[WIN_MR];
  assign data_o_6     = win_p1[WIN_BL];
  assign data_o_7     = win_p1[WIN_BC];
  assign data_o_8     = win_p1[WIN_BR];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 image: fixed window table plus a
// scoreboard built from an image array of the current frame.
module tb_sobel_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;

  typedef logic [8:0][PW-1:0] win_t;
  typedef struct packed {
    win_t px;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pix = '0;
  logic          pix_valid = 1'b0;
  logic          sof = 1'b0;
  logic          win_ready = 1'b1;
  logic          pix_ready, win_valid, frame_done;
  logic [PW-1:0] d [9];

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk_i_s      (clk),
    .rst_i_s      (rst),
    .pix_i        (pix),
    .pix_valid_i  (pix_valid),
    .sof_i        (sof),
    .pix_ready_o  (pix_ready),
    .data_o_0     (d[0]),
    .data_o_1     (d[1]),
    .data_o_2     (d[2]),
    .data_o_3     (d[3]),
    .data_o_4     (d[4]),
    .data_o_5     (d[5]),
    .data_o_6     (d[6]),
    .data_o_7     (d[7]),
    .data_o_8     (d[8]),
    .win_valid_o  (win_valid),
    .win_ready_i  (win_ready),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   mr = 0, mc = 0;
  bit   done_pend = 0, acc_flag = 0, prev_valid = 0, prev_ready = 0;
  win_t prev_data;
  logic [PW-1:0] img [H][W];
  win_t exp_q [$];
  win_t cap_q [$];
  vec_t tbl [4];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input win_t act, input win_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic win_t pack_out();
    win_t w;
    for (int k = 0; k < 9; k++) w[8-k] = d[k];
    return w;
  endfunction

  // Reference: place the pixel in the frame image; an interior position yields
  // the 3x3 neighbourhood ending at it.
  function automatic void model_accept(input logic [PW-1:0] p, input bit s);
    int   r, c;
    win_t w;
    r = s ? 0 : mr;
    c = s ? 0 : mc;
    img[r][c] = p;
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++) w[8-k] = img[r-2+k/3][c-2+k%3];
      exp_q.push_back(w);
    end
    if (c == W-1) begin
      mc = 0;
      if (r == H-1) begin
        mr = 0;
        done_pend = 1;
      end else begin
        mr = r + 1;
      end
    end else begin
      mc = c + 1;
      mr = r;
    end
  endfunction

  // Monitor: sampled mid-cycle, decides what the next rising edge does.
  always @(negedge clk) begin
    win_t cur;
    cur = pack_out();
    if (rst) begin
      mr = 0; mc = 0; exp_q.delete(); done_pend = 0; prev_valid = 0; acc_flag = 0;
    end else begin
      if (done_pend || frame_done) chk("frame_done", frame_done, done_pend);
      if (frame_done) done_cnt++;
      done_pend = 0;
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", win_valid, 1);
        chkw("stall_data", cur, prev_data);
      end
      if (win_valid && !win_ready) chk("stall_pix_ready", pix_ready, 0);
      if (win_valid && win_ready) begin
        chk("window_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chkw("window", cur, exp_q.pop_front());
        cap_q.push_back(cur);
      end
      prev_valid = win_valid;
      prev_ready = win_ready;
      prev_data  = cur;
      acc_flag   = pix_valid && pix_ready;
      if (acc_flag) model_accept(pix, sof);
    end
  end

  task automatic send(input logic [PW-1:0] p, input bit s);
    int n = 0;
    pix = p; sof = s; pix_valid = 1'b1;
    do begin
      @(posedge clk);
      n++;
    end while (!acc_flag && n < 50);
    if (!acc_flag) begin
      tests++; fails++;
      $display("FAIL accept_timeout: pixel %0d not taken after %0d cycles", p, n);
    end
    #1;
    pix_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit idle_rand, input bit use_sof);
    for (int i = 0; i < W*H; i++) begin
      if (idle_rand && ($urandom % 2 == 1)) begin
        @(posedge clk); #1;
      end
      send(PW'(base + i), use_sof && (i == 0));
    end
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk({nm, "_win_valid"}, win_valid, 0);
    chk({nm, "_frame_done"}, frame_done, 0);
    chk({nm, "_pix_ready"}, pix_ready, 1);
    chkw({nm, "_data"}, pack_out(), '0);
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string nm, input int base, input int first);
    win_t e;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 9; j++) e[j] = tbl[k].px[j] + PW'(base);
      if (first + k < cap_q.size()) chkw($sformatf("%s_win%0d", nm, k), cap_q[first+k], e);
      else chk($sformatf("%s_win%0d_present", nm, k), cap_q.size(), first + k + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit stop;
    tbl[0].px = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    tbl[1].px = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    tbl[2].px = {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
    tbl[3].px = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};

    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // 1: plain frame
    cap_q.delete(); d0 = done_cnt;
    send_frame(0, 0, 1);
    drain();
    chk("t1_count", cap_q.size(), 4);
    check_frame("t1", 0, 0);
    chk("t1_done", done_cnt - d0, 1);

    // 2: downstream stalls 5 cycles once the first window appears
    cap_q.delete(); d0 = done_cnt;
    fork
      send_frame(0, 0, 1);
      begin
        for (int n = 0; n < 200; n++) begin
          @(posedge clk); #1;
          if (win_valid) break;
        end
        win_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        win_ready = 1'b1;
      end
    join
    drain();
    chk("t2_count", cap_q.size(), 4);
    check_frame("t2", 0, 0);
    chk("t2_done", done_cnt - d0, 1);

    // 3: back-to-back frames
    cap_q.delete(); d0 = done_cnt;
    send_frame(0, 0, 1);
    send_frame(100, 0, 1);
    drain();
    chk("t3_count", cap_q.size(), 8);
    check_frame("t3a", 0, 0);
    check_frame("t3b", 100, 4);
    chk("t3_done", done_cnt - d0, 2);

    // 4: sof on the 7th pixel restarts the frame
    cap_q.delete(); d0 = done_cnt;
    for (int i = 0; i < 6; i++) send(PW'(50 + i), i == 0);
    send_frame(0, 0, 1);
    drain();
    chk("t4_count", cap_q.size(), 4);
    check_frame("t4", 0, 0);
    chk("t4_done", done_cnt - d0, 1);

    // 5: reset after 9 pixels, next frame without sof
    for (int i = 0; i < 9; i++) send(PW'(70 + i), i == 0);
    do_reset("t5_reset");
    cap_q.delete(); d0 = done_cnt;
    send_frame(0, 0, 0);
    drain();
    chk("t5_count", cap_q.size(), 4);
    check_frame("t5", 0, 0);
    chk("t5_done", done_cnt - d0, 1);

    // 6: random gaps in pix_valid
    cap_q.delete(); d0 = done_cnt;
    send_frame(0, 1, 1);
    drain();
    chk("t6_count", cap_q.size(), 4);
    check_frame("t6", 0, 0);
    chk("t6_done", done_cnt - d0, 1);

    // 7: random pixels, random valid gaps and random downstream ready
    cap_q.delete(); d0 = done_cnt; stop = 0;
    fork
      begin
        for (int f = 0; f < 2; f++) begin
          for (int i = 0; i < W*H; i++) begin
            if ($urandom % 2 == 1) begin
              @(posedge clk); #1;
            end
            send(PW'($urandom), i == 0);
          end
        end
        stop = 1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          win_ready = ($urandom % 2 == 1);
        end
        win_ready = 1'b1;
      end
    join
    drain();
    chk("t7_count", cap_q.size(), 8);
    chk("t7_done", done_cnt - d0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
